// File: rtl/hdspsr_pwr_pkg.sv
// Shared types for the HDSPSR power sequencer: FSM states and the 2-bit stable state codes.
package hdspsr_pwr_pkg;

  typedef enum logic [2:0] {
    ST_ACTIVE,
    ST_FS,
    ST_DS,
    ST_ENTER_FS,
    ST_ENTER_DS,
    ST_EXIT_DS,
    ST_EXIT_FS,
    ST_RST
  } pwr_state_e;

  localparam logic [1:0] PWR_ACTIVE = 2'b00;
  localparam logic [1:0] PWR_FS     = 2'b01;
  localparam logic [1:0] PWR_DS     = 2'b10;

  // The unused 2'b11 request code is folded into deepsleep.
  function automatic logic [1:0] decodeReq(input logic [1:0] req);
    case (req)
      2'b00:   return PWR_ACTIVE;
      2'b01:   return PWR_FS;
      default: return PWR_DS;
    endcase
  endfunction

endpackage

// File: rtl/hdspsr_pwr_bank_stepper.sv
// Stagger counter plus bank index: one step pulse per bank every STAGGER_CYC cycles,
// then a done pulse one further STAGGER_CYC after the last bank.
module hdspsr_pwr_bank_stepper #(
  parameter int NUM_BANKS   = 4,
  parameter int STAGGER_CYC = 2,
  parameter int CNT_W       = 2,
  parameter int IDX_W       = $clog2(NUM_BANKS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_run,
  output logic             o_step,
  output logic             o_done,
  output logic [IDX_W-1:0] o_bankIdx
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BANKS);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             w_tick;

  assign w_tick    = i_run && (r_cnt == '0);
  assign o_step    = w_tick && (r_idx != IDX_LAST);
  assign o_done    = w_tick && (r_idx == IDX_LAST);
  assign o_bankIdx = r_idx;

  // Clearing on done lets a chained transient state start its own bank 0 immediately.
  always_ff @(posedge clk) begin
    if (reset || !i_run || o_done) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
      if (o_step) r_idx <= r_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/hdspsr_pwr_seq.sv
// hdspsr_pwr_seq: staggered per-bank fastsleep/deepsleep sequencer with array reset hold.
// Define HDSPSR_PWR_OVRD_SYNC_EN to pass the TDR override inputs through 2-flop synchronizers.
module hdspsr_pwr_seq
  import hdspsr_pwr_pkg::*;
#(
  parameter int NUM_BANKS   = 4,
  parameter int STAGGER_CYC = 2,
  parameter int RST_CYC     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           pwr_req,
  input  logic                 pwr_req_valid,
  output logic                 pwr_req_ready,
  output logic [1:0]           pwr_state,
  output logic                 pwr_busy,
  input  logic                 hdspsr_pwr_mgmt_ovrd_en,
  input  logic                 hdspsr_fastsleep_override,
  input  logic                 hdspsr_deepsleep_override,
  input  logic                 hdspsr_async_rst_override,
  output logic [NUM_BANKS-1:0] array_fastsleep,
  output logic [NUM_BANKS-1:0] array_deepsleep,
  output logic                 array_rst
);

  localparam int MAX_CYC = (STAGGER_CYC > RST_CYC) ? STAGGER_CYC : RST_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(NUM_BANKS + 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);

  logic w_ovrdEn, w_fsOvrd, w_dsOvrd, w_rstOvrd;

`ifdef HDSPSR_PWR_OVRD_SYNC_EN
  logic [3:0] r_ovrdMeta;
  logic [3:0] r_ovrdSync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovrdMeta <= '0;
      r_ovrdSync <= '0;
    end else begin
      r_ovrdMeta <= {hdspsr_pwr_mgmt_ovrd_en, hdspsr_fastsleep_override,
                     hdspsr_deepsleep_override, hdspsr_async_rst_override};
      r_ovrdSync <= r_ovrdMeta;
    end
  end

  assign {w_ovrdEn, w_fsOvrd, w_dsOvrd, w_rstOvrd} = r_ovrdSync;
`else
  assign {w_ovrdEn, w_fsOvrd, w_dsOvrd, w_rstOvrd} = {hdspsr_pwr_mgmt_ovrd_en, hdspsr_fastsleep_override,
                                                      hdspsr_deepsleep_override, hdspsr_async_rst_override};
`endif

  pwr_state_e           r_state, w_nextState;
  logic [1:0]           r_req, r_goal, r_pwrState;
  logic                 r_viaDs;
  logic [CNT_W-1:0]     r_rstCnt;
  logic [NUM_BANKS-1:0] r_fs, r_ds;
  logic                 r_arrayRst;
  logic                 w_stable, w_ready, w_accept;
  logic [1:0]           w_ovrdTarget, w_target;
  logic                 w_stepRun, w_rstPulse, w_step, w_stepDone;
  logic [IDX_W-1:0]     w_bankIdx;
  logic [NUM_BANKS-1:0] w_bankSel;

  assign w_stable     = (r_state == ST_ACTIVE) || (r_state == ST_FS) || (r_state == ST_DS);
  assign w_ready      = w_stable && !w_ovrdEn;
  assign w_accept     = pwr_req_valid && w_ready;
  assign w_ovrdTarget = w_dsOvrd ? PWR_DS : (w_fsOvrd ? PWR_FS : PWR_ACTIVE);
  assign w_target     = w_ovrdEn ? w_ovrdTarget : (w_accept ? decodeReq(pwr_req) : r_req);
  assign w_bankSel    = NUM_BANKS'(1) << w_bankIdx;

  hdspsr_pwr_bank_stepper #(
    .NUM_BANKS  (NUM_BANKS),
    .STAGGER_CYC(STAGGER_CYC),
    .CNT_W      (CNT_W),
    .IDX_W      (IDX_W)
  ) u_stepper (
    .clk      (clk),
    .reset    (reset),
    .i_run    (w_stepRun),
    .o_step   (w_step),
    .o_done   (w_stepDone),
    .o_bankIdx(w_bankIdx)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_ACTIVE;
    else       r_state <= w_nextState;
  end

  // Transient states chain on the goal and origin captured while last stable.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_ACTIVE:   if (w_target != PWR_ACTIVE) w_nextState = ST_ENTER_FS;
      ST_FS: begin
        if (w_target == PWR_DS)          w_nextState = ST_ENTER_DS;
        else if (w_target == PWR_ACTIVE) w_nextState = ST_EXIT_FS;
      end
      ST_DS:       if (w_target != PWR_DS) w_nextState = ST_EXIT_DS;
      ST_ENTER_FS: if (w_stepDone) w_nextState = (r_goal == PWR_DS) ? ST_ENTER_DS : ST_FS;
      ST_ENTER_DS: if (w_stepDone) w_nextState = ST_DS;
      ST_EXIT_DS:  if (w_stepDone) w_nextState = (r_goal == PWR_ACTIVE) ? ST_EXIT_FS : ST_FS;
      ST_EXIT_FS:  if (w_stepDone) w_nextState = r_viaDs ? ST_RST : ST_ACTIVE;
      ST_RST:      if (r_rstCnt == RST_LAST) w_nextState = ST_ACTIVE;
      default:     w_nextState = ST_ACTIVE;
    endcase
  end

  always_comb begin
    w_stepRun  = 1'b0;
    w_rstPulse = 1'b0;
    case (r_state)
      ST_ENTER_FS, ST_ENTER_DS, ST_EXIT_DS, ST_EXIT_FS: w_stepRun = 1'b1;
      ST_RST:  w_rstPulse = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req      <= PWR_ACTIVE;
      r_goal     <= PWR_ACTIVE;
      r_viaDs    <= 1'b0;
      r_pwrState <= PWR_ACTIVE;
      r_rstCnt   <= '0;
      r_arrayRst <= 1'b0;
    end else begin
      if (w_accept) r_req <= decodeReq(pwr_req);
      if (w_stable) begin
        r_goal  <= w_target;
        r_viaDs <= (r_state == ST_DS);
      end
      case (w_nextState)
        ST_ACTIVE: r_pwrState <= PWR_ACTIVE;
        ST_FS:     r_pwrState <= PWR_FS;
        ST_DS:     r_pwrState <= PWR_DS;
        default:   ;
      endcase
      if (r_state != ST_RST)        r_rstCnt <= '0;
      else if (r_rstCnt != RST_LAST) r_rstCnt <= r_rstCnt + CNT_W'(1);
      r_arrayRst <= w_rstPulse || (w_ovrdEn && w_rstOvrd);
    end
  end

  // Deepsleep is only set once all fastsleep bits are on and cleared before any fastsleep bit drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs <= '0;
      r_ds <= '0;
    end else if (w_step) begin
      case (r_state)
        ST_ENTER_FS: r_fs <= r_fs | w_bankSel;
        ST_ENTER_DS: r_ds <= r_ds | w_bankSel;
        ST_EXIT_DS:  r_ds <= r_ds & ~w_bankSel;
        ST_EXIT_FS:  r_fs <= r_fs & ~w_bankSel;
        default:     ;
      endcase
    end
  end

  assign pwr_req_ready   = w_ready;
  assign pwr_busy        = !w_stable;
  assign pwr_state       = r_pwrState;
  assign array_fastsleep = r_fs;
  assign array_deepsleep = r_ds;
  assign array_rst       = r_arrayRst;

endmodule

// File: tb/tb_hdspsr_pwr_seq.sv
// Bench for hdspsr_pwr_seq: a frame-schedule model of each power transition checked every cycle,
// plus literal expectations at key points of each directed scenario.
module tb_hdspsr_pwr_seq;

  localparam int NB = 4;
  localparam int SC = 2;
  localparam int RC = 3;
  localparam logic [NB-1:0] FULL = 4'hF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    pwr_req = 2'b00;
  logic          pwr_req_valid = 1'b0;
  logic          pwr_req_ready;
  logic [1:0]    pwr_state;
  logic          pwr_busy;
  logic          ovrdEn = 1'b0, fsOvrd = 1'b0, dsOvrd = 1'b0, rstOvrd = 1'b0;
  logic [NB-1:0] array_fastsleep, array_deepsleep;
  logic          array_rst;

  always #5 clk = ~clk;

  hdspsr_pwr_seq #(.NUM_BANKS(NB), .STAGGER_CYC(SC), .RST_CYC(RC)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .pwr_req                  (pwr_req),
    .pwr_req_valid            (pwr_req_valid),
    .pwr_req_ready            (pwr_req_ready),
    .pwr_state                (pwr_state),
    .pwr_busy                 (pwr_busy),
    .hdspsr_pwr_mgmt_ovrd_en  (ovrdEn),
    .hdspsr_fastsleep_override(fsOvrd),
    .hdspsr_deepsleep_override(dsOvrd),
    .hdspsr_async_rst_override(rstOvrd),
    .array_fastsleep          (array_fastsleep),
    .array_deepsleep          (array_deepsleep),
    .array_rst                (array_rst)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: every transition is expanded into the list of output frames seen after each clock edge.
  typedef struct packed {
    logic [NB-1:0] fs;
    logic [NB-1:0] ds;
    logic          rstPulse;
    logic          busy;
    logic [1:0]    code;
  } frame_t;

  frame_t        frameQ[$];
  logic [NB-1:0] mFs = '0, mDs = '0, bFs, bDs;
  logic          mRstPulse = 1'b0, mBusy = 1'b0, mArrayRst = 1'b0;
  logic [1:0]    mCode = 2'b00, mLastReq = 2'b00, bCode;
  bit            mValid = 1'b0;

  function automatic logic [NB-1:0] lowMask(input int cnt);
    return NB'((32'd1 << cnt) - 32'd1);
  endfunction

  task automatic pushFrame(input logic rstPulse, input logic busy, input logic [1:0] code);
    frame_t f;
    f.fs = bFs; f.ds = bDs; f.rstPulse = rstPulse; f.busy = busy; f.code = code;
    frameQ.push_back(f);
  endtask

  // kind: 0 set fastsleep, 1 set deepsleep, 2 clear deepsleep, 3 clear fastsleep
  task automatic pushBankSeg(input int kind);
    for (int j = 0; j <= NB * SC; j++) begin
      int cnt;
      if (j > 0) begin
        cnt = (j - 1) / SC + 1;
        if (cnt > NB) cnt = NB;
        case (kind)
          0: bFs = lowMask(cnt);
          1: bDs = lowMask(cnt);
          2: bDs = FULL & ~lowMask(cnt);
          default: bFs = FULL & ~lowMask(cnt);
        endcase
      end
      pushFrame(1'b0, 1'b1, bCode);
    end
  endtask

  task automatic planPath(input logic [1:0] from, input logic [1:0] to);
    bFs = mFs; bDs = mDs; bCode = from;
    if (from == 2'b00) begin
      pushBankSeg(0);
      if (to == 2'b10) pushBankSeg(1);
    end else if (from == 2'b01) begin
      if (to == 2'b10) pushBankSeg(1);
      else             pushBankSeg(3);
    end else begin
      pushBankSeg(2);
      if (to == 2'b00) begin
        pushBankSeg(3);
        for (int r = 0; r < RC; r++) pushFrame(1'b1, 1'b1, bCode);
      end
    end
    pushFrame(1'b0, 1'b0, to);
  endtask

  always @(posedge clk) begin : modelProc
    logic [1:0] tgt;
    frame_t     f;
    if (reset) begin
      frameQ.delete();
      mFs = '0; mDs = '0; mRstPulse = 1'b0; mBusy = 1'b0; mArrayRst = 1'b0;
      mCode = 2'b00; mLastReq = 2'b00; mValid = 1'b1;
    end else begin
      mArrayRst = mRstPulse | (ovrdEn & rstOvrd);
      if (frameQ.size() == 0) begin
        if (!ovrdEn && pwr_req_valid)
          mLastReq = (pwr_req == 2'b00) ? 2'b00 : (pwr_req == 2'b01) ? 2'b01 : 2'b10;
        tgt = ovrdEn ? (dsOvrd ? 2'b10 : (fsOvrd ? 2'b01 : 2'b00)) : mLastReq;
        if (tgt != mCode) planPath(mCode, tgt);
      end
      if (frameQ.size() > 0) begin
        f = frameQ.pop_front();
        mFs = f.fs; mDs = f.ds; mRstPulse = f.rstPulse; mBusy = f.busy; mCode = f.code;
      end
    end
  end

  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("array_fastsleep", 32'(array_fastsleep), 32'(mFs));
      checkOutput("array_deepsleep", 32'(array_deepsleep), 32'(mDs));
      checkOutput("array_rst", 32'(array_rst), 32'(mArrayRst));
      checkOutput("pwr_busy", 32'(pwr_busy), 32'(mBusy));
      checkOutput("pwr_state", 32'(pwr_state), 32'(mCode));
      checkOutput("pwr_req_ready", 32'(pwr_req_ready), 32'(!mBusy && !ovrdEn));
      checkOutput("ds_implies_fs", 32'(array_deepsleep & ~array_fastsleep), 32'd0);
    end
  end

  logic [NB-1:0] fsAt[0:31];
  logic [NB-1:0] dsAt[0:31];
  logic [1:0]    stAt[0:31];
  logic          busyAt[0:31];
  logic          rstAt[0:31];

  task automatic applyStimulus(input logic [1:0] req, input logic valid);
    pwr_req = req;
    pwr_req_valid = valid;
  endtask

  task automatic sendReq(input logic [1:0] req);
    @(posedge clk); #1 applyStimulus(req, 1'b1);
    @(posedge clk); #1 applyStimulus(req, 1'b0);
  endtask

  task automatic captureFrames(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      fsAt[k] = array_fastsleep; dsAt[k] = array_deepsleep; stAt[k] = pwr_state;
      busyAt[k] = pwr_busy; rstAt[k] = array_rst;
    end
  endtask

  task automatic waitStable(input string name);
    int n = 0;
    repeat (2) @(negedge clk);
    while ((mBusy || frameQ.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_settled"}, 32'(n < 200), 32'd1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int rstCount;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_state", 32'(pwr_state), 32'd0);
    checkOutput("reset_ready", 32'(pwr_req_ready), 32'd1);
    checkOutput("reset_busy", 32'(pwr_busy), 32'd0);
    checkOutput("reset_arrays", 32'({array_fastsleep, array_deepsleep, array_rst}), 32'd0);

    sendReq(2'b01);
    captureFrames(10);
    checkOutput("fs_busy_f0", 32'(busyAt[0]), 32'd1);
    checkOutput("fs_f1", 32'(fsAt[1]), 32'h1);
    checkOutput("fs_f2", 32'(fsAt[2]), 32'h1);
    checkOutput("fs_f3", 32'(fsAt[3]), 32'h3);
    checkOutput("fs_f5", 32'(fsAt[5]), 32'h7);
    checkOutput("fs_f7", 32'(fsAt[7]), 32'hF);
    checkOutput("fs_state_f8", 32'(stAt[8]), 32'd0);
    checkOutput("fs_state_f9", 32'(stAt[9]), 32'd1);
    checkOutput("fs_busy_f9", 32'(busyAt[9]), 32'd0);
    waitStable("to_fs");

    sendReq(2'b01);
    @(negedge clk);
    checkOutput("same_req_busy", 32'(pwr_busy), 32'd0);
    checkOutput("same_req_fs", 32'(array_fastsleep), 32'hF);
    checkOutput("same_req_state", 32'(pwr_state), 32'd1);

    sendReq(2'b00);
    captureFrames(12);
    rstCount = 0;
    for (int k = 0; k < 12; k++) rstCount += int'(rstAt[k]);
    checkOutput("fs_exit_no_rst", 32'(rstCount), 32'd0);
    checkOutput("fs_exit_f1", 32'(fsAt[1]), 32'hE);
    checkOutput("fs_exit_state_f9", 32'(stAt[9]), 32'd0);
    waitStable("fs_to_active");

    sendReq(2'b10);
    captureFrames(19);
    checkOutput("ds_f8_fs", 32'(fsAt[8]), 32'hF);
    checkOutput("ds_f9_ds", 32'(dsAt[9]), 32'h0);
    checkOutput("ds_f10_ds", 32'(dsAt[10]), 32'h1);
    checkOutput("ds_state_f17", 32'(stAt[17]), 32'd0);
    checkOutput("ds_state_f18", 32'(stAt[18]), 32'd2);
    checkOutput("ds_full_f18", 32'({fsAt[18], dsAt[18]}), 32'hFF);
    waitStable("to_ds");

    sendReq(2'b00);
    captureFrames(24);
    rstCount = 0;
    for (int k = 0; k < 24; k++) rstCount += int'(rstAt[k]);
    checkOutput("wake_rst_cycles", 32'(rstCount), 32'd3);
    checkOutput("wake_f1_ds", 32'(dsAt[1]), 32'hE);
    checkOutput("wake_rst_f18", 32'(rstAt[18]), 32'd0);
    checkOutput("wake_rst_f19", 32'(rstAt[19]), 32'd1);
    checkOutput("wake_rst_f22", 32'(rstAt[22]), 32'd0);
    checkOutput("wake_state_f20", 32'(stAt[20]), 32'd2);
    checkOutput("wake_state_f21", 32'(stAt[21]), 32'd0);
    waitStable("ds_to_active");

    @(posedge clk); #1 ovrdEn = 1'b1; dsOvrd = 1'b1; applyStimulus(2'b01, 1'b1);
    @(negedge clk);
    checkOutput("ovrd_ready", 32'(pwr_req_ready), 32'd0);
    waitStable("ovrd_to_ds");
    applyStimulus(2'b00, 1'b0);
    checkOutput("ovrd_state", 32'(pwr_state), 32'd2);
    @(posedge clk); #1 rstOvrd = 1'b1;
    @(negedge clk);
    checkOutput("ovrd_rst_latency", 32'(array_rst), 32'd0);
    @(negedge clk);
    checkOutput("ovrd_rst", 32'(array_rst), 32'd1);
    @(posedge clk); #1 rstOvrd = 1'b0; dsOvrd = 1'b0; ovrdEn = 1'b0;
    waitStable("ovrd_release");
    checkOutput("ovrd_release_state", 32'(pwr_state), 32'd0);

    sendReq(2'b01);
    waitStable("fs_again");
    sendReq(2'b10);
    captureFrames(10);
    checkOutput("fs_to_ds_f8", 32'(dsAt[8]), 32'hF);
    checkOutput("fs_to_ds_state_f9", 32'(stAt[9]), 32'd2);
    waitStable("fs_to_ds");
    sendReq(2'b01);
    captureFrames(10);
    checkOutput("ds_to_fs_f9", 32'({fsAt[9], dsAt[9], 2'(stAt[9])}), 32'h3C1);
    waitStable("ds_to_fs");
    sendReq(2'b00);
    waitStable("back_to_active");

    sendReq(2'b11);
    captureFrames(15);
    checkOutput("mid_ds_f14", 32'(dsAt[14]), 32'h7);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_arrays", 32'({array_fastsleep, array_deepsleep, array_rst}), 32'd0);
    checkOutput("abort_state", 32'(pwr_state), 32'd0);
    checkOutput("abort_ready", 32'(pwr_req_ready), 32'd1);
    checkOutput("abort_busy", 32'(pwr_busy), 32'd0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
